// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one data-memory port between instruction fetch (IF, read-only)
//   and the memory stage (D, loads and stores). Only one transaction may be
//   outstanding. D has fixed priority, but IF is forced to win once it has
//   lost STARVE_LIMIT contested cycles in a row.
//
// Handshake semantics (all three request channels):
//   A requester raises req and holds req plus its fields stable until its
//   gnt is seen high in the same cycle. A memory request is accepted on a
//   cycle where mem_req && mem_gnt. Exactly one mem_rvalid comes back per
//   accepted request, no earlier than the following cycle, and it is routed
//   to the owner as a one-cycle rvalid pulse. For a store, rvalid is the ack.
//
// Ports:
//   clk, n_reset                    clock, async active-low reset
//   if_req/if_addr                  IF read request
//   if_gnt/if_rvalid/if_rdata       IF accept and response
//   d_req/d_we/d_addr/d_wdata/d_be  D request
//   d_gnt/d_rvalid/d_rdata          D accept and response
//   mem_*                           memory-side request and response
//   busy                            a transaction is outstanding
//   dbg_state, dbg_starve_cnt       FSM state and starvation counter
module mem_port_arbiter #(
    parameter int ADDR_W       = 48,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4,
    localparam int BE_W  = DATA_W / 8,
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state,
    output logic [CNT_W-1:0]  dbg_starve_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_D  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             force_if;
    logic             sel_if;
    logic             sel_d;

    // Selection is only meaningful in IDLE; gating with n_reset keeps every
    // output at zero while reset is held even though the paths are
    // combinational from the requester inputs.
    always_comb begin
        force_if = (starve_cnt == LIMIT) && if_req;
        sel_if   = n_reset && (state == IDLE) && (force_if || (!d_req && if_req));
        sel_d    = n_reset && (state == IDLE) && !force_if && d_req;
    end

    always_comb begin
        mem_req   = sel_if || sel_d;
        mem_we    = sel_d && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (sel_d) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end else if (sel_if) begin
            mem_addr  = if_addr;
            mem_be    = {BE_W{1'b1}};
        end
    end

    always_comb begin
        if_gnt    = sel_if && mem_gnt;
        d_gnt     = sel_d && mem_gnt;
        // A response in IDLE (including one left over from a request that
        // reset aborted) matches neither wait state and is dropped here.
        if_rvalid = n_reset && (state == WAIT_IF) && mem_rvalid;
        d_rvalid  = n_reset && (state == WAIT_D) && mem_rvalid;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
        busy      = n_reset && (state != IDLE);
    end

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_gnt) begin
                        state      <= WAIT_IF;
                        starve_cnt <= '0;
                    end else begin
                        if (d_gnt) state <= WAIT_D;
                        // A contested loss counts even when memory stalls.
                        if (if_req && sel_d && starve_cnt != LIMIT)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                WAIT_IF, WAIT_D: begin
                    if (mem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W = 48;
    localparam int DATA_W = 64;
    localparam int BE_W   = DATA_W / 8;

    // clock / reset
    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    logic              if_req = 0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt, if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req = 0, d_we = 0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [BE_W-1:0]   d_be = '0;
    logic              d_gnt, d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_gnt = 0, mem_rvalid = 0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              busy;
    logic [1:0]        dbg_state;
    logic [2:0]        dbg_starve_cnt;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .n_reset(n_reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // scoreboard
    int n_cmp = 0;
    int n_mis = 0;
    logic [1:0] exp_q[$];  // expected grant winner {if_gnt, d_gnt}

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge,
    // outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // In IDLE with requests held: check counter and winner, then answer the
    // accepted request one cycle later.
    task automatic accept_step(input logic [2:0] exp_cnt);
        logic [1:0]        who;
        logic [DATA_W-1:0] data;
        who  = exp_q.pop_front();
        data = {$urandom, $urandom};
        check("starve_cnt", dbg_starve_cnt, exp_cnt);
        check("grant", {if_gnt, d_gnt}, who);
        check("mem_addr", mem_addr, who[1] ? if_addr : d_addr);
        tick();
        mem_rvalid = 1;
        mem_rdata  = data;
        #1;
        check("rvalid", {if_rvalid, d_rvalid}, who);
        check("rdata", who[1] ? if_rdata : d_rdata, data);
        tick();
        mem_rvalid = 0;
        mem_rdata  = '0;
        #1;
    endtask

    localparam logic [1:0] W_IF = 2'b10;
    localparam logic [1:0] W_D  = 2'b01;

    initial begin
        logic [1:0] who_tab[14];
        logic [2:0] cnt_tab[14];
        who_tab = '{W_D, W_D, W_D, W_D, W_IF, W_D, W_D, W_D, W_D, W_IF, W_D, W_D, W_D, W_D};
        cnt_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                    3'd0, 3'd1, 3'd2, 3'd3};

        // reset: outputs stay zero even with a request and grant present
        if_req = 1; if_addr = 48'h1000; mem_gnt = 1; mem_rvalid = 1;
        #12;
        check("rst_mem_req", mem_req, 0);
        check("rst_if_gnt", if_gnt, 0);
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", dbg_starve_cnt, 0);
        if_req = 0; mem_gnt = 0; mem_rvalid = 0;
        #2;
        n_reset = 1;
        tick();

        // IF-only read
        if_req = 1; if_addr = 48'h1000; mem_gnt = 1;
        #1;
        check("if_gnt_c0", if_gnt, 1);
        check("if_mem_req", mem_req, 1);
        check("if_mem_addr", mem_addr, 48'h1000);
        check("if_mem_be", mem_be, 8'hFF);
        check("if_mem_we", mem_we, 0);
        check("if_d_gnt", d_gnt, 0);
        tick();
        if_req = 0; mem_gnt = 0;
        #1;
        check("if_busy_c1", busy, 1);
        check("if_mem_req_c1", mem_req, 0);
        check("if_rvalid_c1", if_rvalid, 0);
        tick();
        mem_rvalid = 1; mem_rdata = 64'hDEADBEEF_00000013;
        #1;
        check("if_rvalid_c2", if_rvalid, 1);
        check("if_rdata_c2", if_rdata, 64'hDEADBEEF_00000013);
        check("if_busy_c2", busy, 1);
        check("if_d_rvalid_c2", d_rvalid, 0);
        tick();
        mem_rvalid = 0; mem_rdata = '0;
        #1;
        check("if_busy_c3", busy, 0);
        check("if_rvalid_c3", if_rvalid, 0);

        // D store
        d_req = 1; d_we = 1; d_addr = 48'h2008; d_wdata = 64'h1122334455667788;
        d_be = 8'h0F; mem_gnt = 1;
        #1;
        check("st_d_gnt", d_gnt, 1);
        check("st_mem_we", mem_we, 1);
        check("st_mem_be", mem_be, 8'h0F);
        check("st_mem_addr", mem_addr, 48'h2008);
        check("st_mem_wdata", mem_wdata, 64'h1122334455667788);
        tick();
        d_req = 0; d_we = 0; mem_gnt = 0;
        #1;
        check("st_d_rvalid_wait", d_rvalid, 0);
        check("st_d_rdata_wait", d_rdata, 0);
        tick();
        mem_rvalid = 1;
        #1;
        check("st_d_rvalid", d_rvalid, 1);
        check("st_d_rdata", d_rdata, 0);
        check("st_if_rvalid", if_rvalid, 0);
        tick();
        mem_rvalid = 0;
        #1;
        check("st_d_rvalid_end", d_rvalid, 0);

        // D load passes read data through
        d_req = 1; d_we = 0; d_addr = 48'h2010; mem_gnt = 1;
        #1;
        check("ld_d_gnt", d_gnt, 1);
        check("ld_mem_be", mem_be, 8'h0F);
        tick();
        d_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'hA5A5_0000_1234_5678;
        #1;
        check("ld_d_rdata", d_rdata, 64'hA5A5_0000_1234_5678);
        tick();
        mem_rvalid = 0; mem_rdata = '0;
        #1;

        // starvation: both held, response after 1 cycle
        if_req = 1; if_addr = 48'h3000;
        d_req = 1; d_we = 0; d_addr = 48'h4000; d_be = 8'hFF; mem_gnt = 1;
        #1;
        for (int i = 0; i < 14; i++) exp_q.push_back(who_tab[i]);
        for (int i = 0; i < 14; i++) accept_step(cnt_tab[i]);
        check("starve_q_empty", exp_q.size(), 0);

        // forced IF with memory stalling
        mem_gnt = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("force_mem_addr", mem_addr, 48'h3000);
            check("force_mem_req", mem_req, 1);
            check("force_gnts", {if_gnt, d_gnt}, 2'b00);
            check("force_cnt", dbg_starve_cnt, 4);
            tick();
        end
        mem_gnt = 1;
        #1;
        exp_q.push_back(W_IF);
        accept_step(3'd4);
        check("force_cnt_clear", dbg_starve_cnt, 0);

        // reset while in WAIT_D
        d_addr = 48'h5000;
        #1;
        check("rst_d_gnt", d_gnt, 1);
        tick();
        if_req = 0; d_req = 0; mem_gnt = 0;
        #1;
        check("rst_state_wait_d", dbg_state, 2);
        check("rst_cnt_pre", dbg_starve_cnt, 1);
        n_reset = 0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_state", dbg_state, 0);
        check("rst_mid_cnt", dbg_starve_cnt, 0);
        tick();
        n_reset = 1;
        tick();
        mem_rvalid = 1; mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        #1;
        check("rst_post_rvalids", {if_rvalid, d_rvalid}, 2'b00);
        check("rst_post_busy", busy, 0);
        check("rst_post_state", dbg_state, 0);
        tick();
        mem_rvalid = 0; mem_rdata = '0;
        if_req = 1; if_addr = 48'h6000; mem_gnt = 1;
        #1;
        check("rst_if_gnt_after", if_gnt, 1);
        tick();
        if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h0000_0000_6000_0001;
        #1;
        check("rst_if_rvalid_after", if_rvalid, 1);
        check("rst_if_rdata_after", if_rdata, 64'h0000_0000_6000_0001);
        tick();
        mem_rvalid = 0; mem_rdata = '0;
        #1;

        // spurious response in IDLE
        mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("spur_rvalids", {if_rvalid, d_rvalid}, 2'b00);
        check("spur_rdata", if_rdata | d_rdata, 0);
        check("spur_busy", busy, 0);
        check("spur_mem_req", mem_req, 0);
        tick();
        mem_rvalid = 0;
        #1;
        check("spur_state", dbg_state, 0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 64-bit data-memory port between instruction fetch (requester IF) and the memory stage (requester D, loads/stores).
- One outstanding transaction at a time.
- Fixed priority to D, with a starvation counter that forces an IF grant after STARVE_LIMIT consecutive losses.
- Sits between the fetch/memory pipeline stages and the memory interface.

Parameters:
- ADDR_W, 48, byte address width
- DATA_W, 64, data width; byte-enable width = DATA_W/8
- STARVE_LIMIT, 4, consecutive contested cycles IF may lose before it is forced to win (>=1)

Ports:
- clk  in  1  clock, rising edge
- n_reset  in  1  asynchronous active-low reset
- if_req  in  1  IF read request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  IF read address
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  IF read data valid
- if_rdata  out  DATA_W  IF read data
- d_req  in  1  D request; held with d_we/d_addr/d_wdata/d_be until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  D address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables
- d_gnt  out  1  D request accepted this cycle
- d_rvalid  out  1  D response valid (load data, or store ack)
- d_rdata  out  DATA_W  D load data
- mem_req  out  1  request to memory
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_be  out  DATA_W/8  byte enables; all-ones for IF
- mem_gnt  in  1  memory accepts request when mem_req && mem_gnt
- mem_rvalid  in  1  response; exactly one per accepted request, earliest the cycle after acceptance
- mem_rdata  in  DATA_W  read data
- busy  out  1  transaction outstanding

Behaviour:
- FSM states: IDLE, WAIT_IF, WAIT_D. Reset to IDLE.
- While n_reset is low, all outputs are 0 and starve_cnt = 0.
- IDLE selection (combinational):
  - If starve_cnt == STARVE_LIMIT and if_req: select IF.
  - Else if d_req: select D.
  - Else if if_req: select IF.
  - Else nothing; mem_req = 0.
- IDLE drive:
  - mem_req = 1 and the selected requester's fields are passed through combinationally.
  - IF drives mem_we = 0, mem_be = all ones, mem_wdata = 0.
  - Unselected requester fields have no effect.
- Grant: selected gnt = mem_gnt (same cycle). Acceptance moves IDLE -> WAIT_IF or WAIT_D on the next edge. No acceptance: stay IDLE; selection is re-evaluated every cycle.
- WAIT_x:
  - mem_req = 0; both gnts = 0; busy = 1.
  - On mem_rvalid: the owner's rvalid = 1 (combinational) and its rdata = mem_rdata; next state IDLE.
  - The non-owner's rvalid stays 0.
  - rdata outputs are 0 whenever the matching rvalid is 0.
- Minimum turnaround: a new request can be accepted the cycle after rvalid, giving 1 accept per 2 cycles at best.
- mem_rvalid while IDLE is ignored, with no output pulse.
- Starvation counter (width $clog2(STARVE_LIMIT+1)), updated only in IDLE:
  - Increments, saturating at STARVE_LIMIT, on each cycle where if_req && d_req and D is selected, whether or not mem_gnt is high.
  - Cleared when an IF request is accepted.
  - Otherwise holds.
- Simultaneous if_req and d_req with starve_cnt < STARVE_LIMIT: D wins.
- IF wins a forced cycle but mem_gnt = 0: IF stays selected while starve_cnt is saturated and if_req is held.
- A requester dropping req before its gnt is a protocol violation; behaviour is undefined, no recovery required.
- Reset asserted mid-transaction: immediate return to IDLE, counter cleared, pending response discarded. No rvalid is produced after release for the aborted request.

Test Plan:
- IF-only read, addr 0x1000, mem_gnt = 1, rvalid 2 cycles later with rdata 0xDEADBEEF_00000013 -> if_gnt in cycle 0; if_rvalid with that data in cycle 2; busy high for cycles 1-2; d_rvalid never high.
- D store, addr 0x2008, wdata 0x1122334455667788, be 0x0F -> mem_we = 1 and mem_be = 0x0F on the bus; d_rvalid pulses for one cycle on mem_rvalid; d_rdata = 0 unless mem_rdata is passed.
- if_req and d_req held continuously, mem_gnt = 1, response after 1 cycle, STARVE_LIMIT = 4 -> acceptance order D,D,D,D,IF,D,D,D,D,IF; starve_cnt saturates at 4 and clears on the IF accept.
- Forced IF cycle with mem_gnt = 0 for 3 cycles -> IF remains selected (mem_addr = if_addr) throughout; no d_gnt; IF is accepted on the first mem_gnt.
- Reset pulsed while in WAIT_D, then mem_rvalid arrives 1 cycle after release -> no d_rvalid or if_rvalid; state IDLE; a subsequent IF request completes normally.
- Spurious mem_rvalid in IDLE with no requests -> no rvalid outputs; busy = 0; mem_req = 0.
